qnna_seq_ctrl: RTL and testbench

Sequencer for the QNNA matrix datapath. It sits between the Wishbone CSR block and the MAC array. On a CSR kick it latches the M/N/K dimensions and walks an M×N×K loop nest: one MAC-step handshake per k, then one output-writeback handshake per (m,n) element. It drives the done/busy/status lines back to the CSR block.

---
 rtl/qnna_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_qnna_seq_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/qnna_seq_ctrl.sv
// qnna_seq_ctrl: M x N x K loop-nest sequencer between the CSR block and the MAC array.
// A kick latches the dims, offers K MAC steps per output element, then one writeback per (m,n).
//  state | meaning
//  IDLE  | waiting for a kick
//  ISSUE | MAC step (m,n,k) offered on mac_valid
//  WRITE | writeback of element (m,n) offered on out_valid
//  DONE  | one-cycle completion pulse on csr_done
module qnna_seq_ctrl #(
  parameter int DIM_W = 16,
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             csr_kick,
  input  logic             csr_abort,
  input  logic [DIM_W-1:0] csr_dim_m,
  input  logic [DIM_W-1:0] csr_dim_n,
  input  logic [DIM_W-1:0] csr_dim_k,
  input  logic             csr_relu_en,
  output logic             csr_busy,
  output logic             csr_done,
  output logic [31:0]      csr_status,
  output logic             mac_valid,
  input  logic             mac_ready,
  output logic [DIM_W-1:0] mac_m_idx,
  output logic [DIM_W-1:0] mac_n_idx,
  output logic [DIM_W-1:0] mac_k_idx,
  output logic             mac_first,
  output logic             mac_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIM_W-1:0] out_m_idx,
  output logic [DIM_W-1:0] out_n_idx,
  output logic             out_relu
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3
  } state_e;

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] dim_m_q, dim_m_d, dim_n_q, dim_n_d, dim_k_q, dim_k_d;
  logic [DIM_W-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic             relu_q, relu_d;
  logic             done_q, done_d, err_q, err_d, kbusy_q, kbusy_d, abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             k_last, n_last, m_last, dims_zero;
  logic [2:0]       state_bits;
  logic [15:0]      cnt_rpt;

  // Indices never exceed dim-1, so these compares are overflow-free.
  assign k_last    = (k_q == dim_k_q - ONE);
  assign n_last    = (n_q == dim_n_q - ONE);
  assign m_last    = (m_q == dim_m_q - ONE);
  assign dims_zero = (csr_dim_m == '0) || (csr_dim_n == '0) || (csr_dim_k == '0);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      dim_m_q <= '0;
      dim_n_q <= '0;
      dim_k_q <= '0;
      m_q     <= '0;
      n_q     <= '0;
      k_q     <= '0;
      relu_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      kbusy_q <= 1'b0;
      abort_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dim_m_q <= dim_m_d;
      dim_n_q <= dim_n_d;
      dim_k_q <= dim_k_d;
      m_q     <= m_d;
      n_q     <= n_d;
      k_q     <= k_d;
      relu_q  <= relu_d;
      done_q  <= done_d;
      err_q   <= err_d;
      kbusy_q <= kbusy_d;
      abort_q <= abort_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dim_m_d = dim_m_q;
    dim_n_d = dim_n_q;
    dim_k_d = dim_k_q;
    m_d     = m_q;
    n_d     = n_q;
    k_d     = k_q;
    relu_d  = relu_q;
    done_d  = done_q;
    err_d   = err_q;
    kbusy_d = kbusy_q;
    abort_d = abort_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (csr_kick) begin
          if (dims_zero) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            dim_m_d = csr_dim_m;
            dim_n_d = csr_dim_n;
            dim_k_d = csr_dim_k;
            relu_d  = csr_relu_en;
            m_d     = '0;
            n_d     = '0;
            k_d     = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            kbusy_d = 1'b0;
            abort_d = 1'b0;
            cnt_d   = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (csr_abort) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (mac_ready) begin
          if (k_last) begin
            k_d     = '0;
            state_d = S_WRITE;
          end else begin
            k_d = k_q + ONE;
          end
        end
      end
      S_WRITE: begin
        if (csr_abort) begin
          abort_d = 1'b1;
          state_d = S_DONE;
        end else if (out_ready) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = S_ISSUE;
          if (!n_last) begin
            n_d = n_q + ONE;
          end else begin
            n_d = '0;
            if (!m_last) m_d = m_q + ONE;
            else         state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (csr_kick && (state_q != S_IDLE)) kbusy_d = 1'b1;
    // Sticky done becomes visible in the DONE cycle itself.
    if (state_d == S_DONE) done_d = 1'b1;
  end

  assign csr_busy  = (state_q == S_ISSUE) || (state_q == S_WRITE);
  assign csr_done  = (state_q == S_DONE);
  assign mac_valid = (state_q == S_ISSUE);
  assign out_valid = (state_q == S_WRITE);
  assign mac_first = mac_valid && (k_q == '0);
  assign mac_last  = mac_valid && k_last;
  assign mac_m_idx = m_q;
  assign mac_n_idx = n_q;
  assign mac_k_idx = k_q;
  assign out_m_idx = m_q;
  assign out_n_idx = n_q;
  assign out_relu  = relu_q;

  assign state_bits = state_q;
  assign cnt_rpt    = 16'(cnt_q);
  assign csr_status = {cnt_rpt, 8'h00, state_bits, abort_q, kbusy_q, err_q, done_q, csr_busy};

endmodule

// File: tb/tb_qnna_seq_ctrl.sv
// Directed bench for qnna_seq_ctrl: a loop-nest reference model checks every busy cycle,
// plus hand-computed checks for reset, zero dims, abort and kick-while-busy.
module tb_qnna_seq_ctrl;
  localparam int DW = 16;
  localparam int CW = 16;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_ni = 1'b0;
  logic          csr_kick = 1'b0;
  logic          csr_abort = 1'b0;
  logic [DW-1:0] csr_dim_m = '0;
  logic [DW-1:0] csr_dim_n = '0;
  logic [DW-1:0] csr_dim_k = '0;
  logic          csr_relu_en = 1'b0;
  logic          mac_ready = 1'b0;
  logic          out_ready = 1'b0;
  logic          csr_busy, csr_done, mac_valid, mac_first, mac_last, out_valid, out_relu;
  logic [31:0]   csr_status;
  logic [DW-1:0] mac_m_idx, mac_n_idx, mac_k_idx, out_m_idx, out_n_idx;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  qnna_seq_ctrl #(.DIM_W(DW), .CNT_W(CW)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .csr_kick   (csr_kick),
    .csr_abort  (csr_abort),
    .csr_dim_m  (csr_dim_m),
    .csr_dim_n  (csr_dim_n),
    .csr_dim_k  (csr_dim_k),
    .csr_relu_en(csr_relu_en),
    .csr_busy   (csr_busy),
    .csr_done   (csr_done),
    .csr_status (csr_status),
    .mac_valid  (mac_valid),
    .mac_ready  (mac_ready),
    .mac_m_idx  (mac_m_idx),
    .mac_n_idx  (mac_n_idx),
    .mac_k_idx  (mac_k_idx),
    .mac_first  (mac_first),
    .mac_last   (mac_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_m_idx  (out_m_idx),
    .out_n_idx  (out_n_idx),
    .out_relu   (out_relu)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Kicks a job and follows it with a loop-nest model; returns in the DONE cycle.
  task automatic run_job(input int dm, input int dn, input int dk, input bit rnd,
                         input bit kick_mid, input bit relu,
                         output int n_mac, output int n_out, output int n_busy);
    int em = 0, en = 0, ek = 0, ph = 1, cyc = 0;
    n_mac = 0;
    n_out = 0;
    n_busy = 0;
    csr_dim_m = 16'(dm);
    csr_dim_n = 16'(dn);
    csr_dim_k = 16'(dk);
    csr_relu_en = relu;
    csr_kick = 1'b1;
    tick();
    csr_kick = 1'b0;
    csr_dim_m = 16'd9;
    csr_dim_n = 16'd9;
    csr_dim_k = 16'd0;
    csr_relu_en = ~relu;
    while (ph != 3 && cyc < 2000) begin
      mac_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      csr_kick = kick_mid && (cyc == 2);
      if (cyc == 0) chk("status_start", 64'(csr_status & ~32'h4), 64'(32'h21));
      if (kick_mid && cyc == 3) chk("kick_busy", 64'(csr_status[3]), 64'(1));
      chk("ctl", 64'({mac_valid, out_valid, csr_busy, csr_done, out_relu}),
          64'({ph == 1, ph == 2, 1'b1, 1'b0, relu}));
      if (ph == 1)
        chk("mac_idx", 64'({mac_first, mac_last, mac_m_idx, mac_n_idx, mac_k_idx}),
            64'({ek == 0, ek == dk - 1, 16'(em), 16'(en), 16'(ek)}));
      if (ph == 2)
        chk("out_idx", 64'({out_m_idx, out_n_idx}), 64'({16'(em), 16'(en)}));
      if (csr_busy) n_busy++;
      tick();
      csr_kick = 1'b0;
      cyc++;
      if (ph == 1 && mac_ready) begin
        n_mac++;
        if (ek == dk - 1) begin
          ek = 0;
          ph = 2;
        end else ek++;
      end else if (ph == 2 && out_ready) begin
        n_out++;
        ph = 1;
        if (en == dn - 1) begin
          en = 0;
          if (em == dm - 1) ph = 3;
          else em++;
        end else en++;
      end
    end
    chk("job_in_budget", 64'(cyc < 2000), 64'(1));
    chk("done_cycle", 64'({csr_done, csr_busy, mac_valid, out_valid}), 64'(4'b1000));
  endtask

  initial begin
    int nm, no, nb;

    // Reset state
    #12;
    chk("rst_status", 64'(csr_status), 64'(0));
    chk("rst_ctl", 64'({csr_busy, csr_done, mac_valid, out_valid, mac_first, mac_last, out_relu}), 64'(0));
    chk("rst_idx", 64'({mac_m_idx, mac_n_idx, mac_k_idx}), 64'(0));
    tick();
    wb_rst_ni = 1'b1;
    tick();
    chk("idle_status", 64'(csr_status), 64'(0));

    // 1x1x1 job: mac at T+1, out at T+2, done at T+3
    run_job(1, 1, 1, 1'b0, 1'b0, 1'b1, nm, no, nb);
    chk("j111_status_done", 64'(csr_status), 64'(32'h0001_0062));
    chk("j111_counts", 64'({16'(nm), 16'(no), 16'(nb)}), 64'({16'd1, 16'd1, 16'd2}));
    tick();
    chk("j111_status_idle", 64'(csr_status), 64'(32'h0001_0002));

    // 2x3x4 job, readies high
    run_job(2, 3, 4, 1'b0, 1'b0, 1'b0, nm, no, nb);
    chk("j234_counts", 64'({16'(nm), 16'(no), 16'(nb)}), 64'({16'd24, 16'd6, 16'd30}));
    chk("j234_status_done", 64'(csr_status), 64'(32'h0006_0062));
    tick();
    chk("j234_status_idle", 64'(csr_status), 64'(32'h0006_0002));

    // Same job with random stalls
    run_job(2, 3, 4, 1'b1, 1'b0, 1'b1, nm, no, nb);
    chk("rnd_counts", 64'({16'(nm), 16'(no)}), 64'({16'd24, 16'd6}));
    chk("rnd_busy_min", 64'(nb >= 30), 64'(1));
    tick();
    chk("rnd_status_idle", 64'(csr_status), 64'(32'h0006_0002));

    // Kick while busy: sticky kick_busy, job undisturbed
    run_job(2, 3, 4, 1'b0, 1'b1, 1'b0, nm, no, nb);
    chk("kb_counts", 64'({16'(nm), 16'(no), 16'(nb)}), 64'({16'd24, 16'd6, 16'd30}));
    chk("kb_status_done", 64'(csr_status), 64'(32'h0006_006A));
    tick();

    // Zero dimension
    mac_ready = 1'b1;
    out_ready = 1'b1;
    csr_dim_m = 16'd2;
    csr_dim_n = 16'd2;
    csr_dim_k = 16'd0;
    csr_kick = 1'b1;
    tick();
    csr_kick = 1'b0;
    chk("zd_ctl", 64'({mac_valid, csr_busy, csr_done}), 64'(3'b001));
    chk("zd_err", 64'({csr_status[7:5], csr_status[2], csr_status[0]}), 64'(5'b011_1_0));
    tick();
    chk("zd_after", 64'({mac_valid, csr_busy, csr_done, csr_status[7:5]}), 64'(6'b000_000));

    // Abort in IDLE ignored
    csr_abort = 1'b1;
    tick();
    chk("abort_idle", 64'({csr_done, csr_busy, csr_status[7:5]}), 64'(5'b0));

    // Kick with abort held in IDLE: kick wins; then abort at k=2
    csr_dim_m = 16'd2;
    csr_dim_n = 16'd3;
    csr_dim_k = 16'd4;
    csr_relu_en = 1'b1;
    csr_kick = 1'b1;
    tick();
    csr_kick = 1'b0;
    csr_abort = 1'b0;
    chk("ka_start", 64'({csr_busy, mac_valid, mac_k_idx}), 64'({2'b11, 16'd0}));
    chk("ka_status", 64'(csr_status & ~32'h4), 64'(32'h21));
    tick();
    tick();
    chk("ab_k2", 64'({mac_valid, mac_k_idx}), 64'({1'b1, 16'd2}));
    csr_abort = 1'b1;
    tick();
    csr_abort = 1'b0;
    chk("ab_done", 64'({csr_done, csr_busy, mac_valid, out_valid}), 64'(4'b1000));
    chk("ab_status", 64'({csr_status[7:5], csr_status[4], csr_status[1]}), 64'(5'b011_1_1));
    tick();
    chk("ab_idle", 64'({csr_done, csr_status[7:5], csr_status[4]}), 64'(5'b0_000_1));

    // Clean job after abort clears aborted and counter
    run_job(1, 1, 1, 1'b0, 1'b0, 1'b0, nm, no, nb);
    chk("post_ab_status", 64'(csr_status & ~32'h4), 64'(32'h0001_0062));
    tick();

    // Asynchronous reset mid-job
    csr_dim_m = 16'd2;
    csr_dim_n = 16'd3;
    csr_dim_k = 16'd4;
    csr_relu_en = 1'b1;
    csr_kick = 1'b1;
    tick();
    csr_kick = 1'b0;
    tick();
    tick();
    chk("pre_rst", 64'({csr_busy, mac_k_idx, out_relu}), 64'({1'b1, 16'd2, 1'b1}));
    #3;
    wb_rst_ni = 1'b0;
    #1;
    chk("arst_status", 64'(csr_status), 64'(0));
    chk("arst_ctl", 64'({csr_busy, csr_done, mac_valid, out_valid, mac_first, mac_last, out_relu}), 64'(0));
    chk("arst_idx", 64'({mac_m_idx, mac_n_idx, mac_k_idx, out_m_idx}), 64'(0));
    #1;
    wb_rst_ni = 1'b1;
    tick();
    chk("post_rst_idle", 64'({csr_busy, csr_status}), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
